// File: rtl/frame_pkg.sv
// Shared frame geometry, asset codes, buffer entry layout and scheduler state
// encoding for the sprite line pipeline.
package frame_pkg;

  localparam logic [9:0] TILELEN_PIXEL = 10'd40;
  localparam logic [9:0] UPSCALE       = 10'd5;
  localparam logic [9:0] SCREENSIZE_H  = 10'd16;
  localparam logic [9:0] SCREENSIZE_V  = 10'd12;
  localparam logic [9:0] H_ACTIVE      = 10'd640;
  localparam logic [9:0] V_ACTIVE      = 10'd480;
  localparam logic [9:0] H_TOTAL       = 10'd800;
  localparam logic [9:0] V_TOTAL       = 10'd525;
  localparam logic [7:0] HIDDEN_POS    = 8'd192;

  localparam logic [3:0] LAST_SLOT = 4'd9;
  localparam logic [2:0] BUF_DEPTH = 3'd4;

  typedef enum logic [3:0] {
    HEART    = 4'd0,
    COIN     = 4'd1,
    KEY      = 4'd2,
    DOOR     = 4'd3,
    WALL     = 4'd4,
    PLAYER_1 = 4'd5,
    PLAYER_2 = 4'd6,
    GOAT_1   = 4'd7,
    GOAT_2   = 4'd8
  } asset_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] col;
    logic [7:0] data;
  } line_entry_t;

  function automatic logic [3:0] tile_row(input logic [9:0] line);
    return 4'(line / TILELEN_PIXEL);
  endfunction

  // Each tile row is 8 sprite rows scaled up by 5 lines each.
  function automatic logic [2:0] sprite_row(input logic [9:0] line);
    return 3'((line % TILELEN_PIXEL) / UPSCALE);
  endfunction

endpackage

// File: rtl/sprite_line_buf.sv
// Double-buffered 4-entry sprite line store: the scan fills the write bank
// while the display bank is searched by column; the banks swap once per line.
module sprite_line_buf
  import frame_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_wr_i,
  input  logic       wr_en_i,
  input  logic [1:0] wr_idx_i,
  input  logic [3:0] wr_col_i,
  input  logic [7:0] wr_data_i,
  input  logic       swap_i,
  input  logic       discard_i,
  input  logic [3:0] look_col_i,
  output logic       hit_o,
  output logic [7:0] data_o
);

  line_entry_t bank_q [2][4];
  logic        disp_sel_q;
  logic        wr_sel_s;

  assign wr_sel_s = ~disp_sel_q;

  // Swap has priority over writes so a scan cut off by the swap leaves nothing behind.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      disp_sel_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < 4; e++) begin
          bank_q[b][e] <= '0;
        end
      end
    end else if (swap_i) begin
      disp_sel_q <= wr_sel_s;
      if (discard_i) begin
        for (int e = 0; e < 4; e++) begin
          bank_q[wr_sel_s][e].valid <= 1'b0;
        end
      end
    end else if (clr_wr_i) begin
      for (int e = 0; e < 4; e++) begin
        bank_q[wr_sel_s][e].valid <= 1'b0;
      end
    end else if (wr_en_i) begin
      bank_q[wr_sel_s][wr_idx_i] <= '{valid: 1'b1, col: wr_col_i, data: wr_data_i};
    end
  end

  // Walk from the highest entry down so the lowest matching entry wins.
  always_comb begin
    logic match_s;
    hit_o  = 1'b0;
    data_o = 8'd0;
    for (int e = 3; e >= 0; e--) begin
      match_s = bank_q[disp_sel_q][e].valid && (bank_q[disp_sel_q][e].col == look_col_i);
      hit_o   = hit_o | match_s;
      data_o  = match_s ? bank_q[disp_sel_q][e].data : data_o;
    end
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-line sprite scheduler: scans the 10 slots during horizontal blanking,
// fetches up to 4 sprite rows from ROM and renders the next line from them.
// Optional SPRITE_OVERFLOW_EN adds sprite_overflow_o for lines with >4 hits.
module sprite_line_scheduler
  import frame_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [9:0]  counter_h_i,
  input  logic [9:0]  counter_v_i,
  input  logic [79:0] slot_pos_i,
  input  logic [19:0] slot_orien_i,
  input  logic [39:0] slot_charc_i,
  output logic        rom_req_o,
  output logic [3:0]  rom_charc_o,
  output logic [1:0]  rom_dir_o,
  output logic [2:0]  rom_index_o,
  input  logic [7:0]  rom_data_i,
  output logic        colour_o,
  output logic        busy_o
`ifdef SPRITE_OVERFLOW_EN
  ,output logic       sprite_overflow_o
`endif
);

  sched_state_e state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic [3:0] row_q, row_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] col_q, col_d;
  logic [3:0] rom_charc_q, rom_charc_d;
  logic [1:0] rom_dir_q, rom_dir_d;
  logic [2:0] rom_index_q, rom_index_d;
  logic       rom_req_q, rom_req_d;
  logic       busy_q, busy_d;
  logic       colour_q, colour_d;

  logic [9:0] target_s;
  logic       trigger_s, swap_s, abort_s;
  logic [7:0] cur_pos_s;
  logic [1:0] cur_orien_s;
  logic [3:0] cur_charc_s;
  logic       hit_s, clr_wr_s, wr_en_s;
  logic       look_hit_s;
  logic [7:0] look_data_s;
  logic [3:0] h_tile_s;
  logic [2:0] h_bit_s;
  logic       active_s;
`ifdef SPRITE_OVERFLOW_EN
  logic       ovf_hit_s;
  logic       ovf_line_q;
  logic       sprite_overflow_q;
`endif

  assign target_s    = (counter_v_i == V_TOTAL - 10'd1) ? 10'd0 : counter_v_i + 10'd1;
  assign trigger_s   = (state_q == IDLE) && (counter_h_i == H_ACTIVE);
  assign swap_s      = (counter_h_i == H_TOTAL - 10'd1);
  assign abort_s     = swap_s && (state_q != IDLE);
  assign cur_pos_s   = slot_pos_i[{slot_q, 3'b000} +: 8];
  assign cur_orien_s = slot_orien_i[{slot_q, 1'b0} +: 2];
  assign cur_charc_s = slot_charc_i[{slot_q, 2'b00} +: 4];
  assign hit_s       = (cur_pos_s < HIDDEN_POS) && (cur_pos_s[7:4] == row_q);

  // Scheduler next state and ROM address selection.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    wcnt_d      = wcnt_q;
    row_d       = row_q;
    idx_d       = idx_q;
    col_d       = col_q;
    rom_charc_d = rom_charc_q;
    rom_dir_d   = rom_dir_q;
    rom_index_d = rom_index_q;
    clr_wr_s    = 1'b0;
    wr_en_s     = 1'b0;
`ifdef SPRITE_OVERFLOW_EN
    ovf_hit_s   = 1'b0;
`endif
    if (abort_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger_s) begin
            clr_wr_s = 1'b1;
            slot_d   = 4'd0;
            wcnt_d   = 3'd0;
            row_d    = tile_row(target_s);
            idx_d    = sprite_row(target_s);
            state_d  = (target_s < V_ACTIVE) ? SCAN : DONE;
          end else begin
            state_d = IDLE;
          end
        end
        SCAN: begin
          if (hit_s && (wcnt_q < BUF_DEPTH)) begin
            state_d     = FETCH;
            col_d       = cur_pos_s[3:0];
            rom_charc_d = cur_charc_s;
            rom_dir_d   = cur_orien_s;
            rom_index_d = idx_q;
          end else begin
`ifdef SPRITE_OVERFLOW_EN
            ovf_hit_s = hit_s;
`endif
            if (slot_q == LAST_SLOT) begin
              state_d = DONE;
            end else begin
              slot_d = slot_q + 4'd1;
            end
          end
        end
        FETCH: state_d = WAIT;
        WAIT: begin
          wr_en_s = 1'b1;
          wcnt_d  = wcnt_q + 3'd1;
          if (slot_q == LAST_SLOT) begin
            state_d = DONE;
          end else begin
            slot_d  = slot_q + 4'd1;
            state_d = SCAN;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign rom_req_d = (state_d == FETCH);
  assign busy_d    = (state_d == SCAN) || (state_d == FETCH) || (state_d == WAIT);

  assign h_tile_s = 4'(counter_h_i / TILELEN_PIXEL);
  assign h_bit_s  = 3'((counter_h_i % TILELEN_PIXEL) / UPSCALE);
  assign active_s = (counter_h_i < H_ACTIVE) && (counter_v_i < V_ACTIVE);
  assign colour_d = (active_s && look_hit_s) ? look_data_s[h_bit_s] : 1'b1;

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      slot_q      <= 4'd0;
      wcnt_q      <= 3'd0;
      row_q       <= 4'd0;
      idx_q       <= 3'd0;
      col_q       <= 4'd0;
      rom_charc_q <= 4'd0;
      rom_dir_q   <= 2'd0;
      rom_index_q <= 3'd0;
      rom_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      colour_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      wcnt_q      <= wcnt_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      rom_charc_q <= rom_charc_d;
      rom_dir_q   <= rom_dir_d;
      rom_index_q <= rom_index_d;
      rom_req_q   <= rom_req_d;
      busy_q      <= busy_d;
      colour_q    <= colour_d;
    end
  end

  sprite_line_buf u_line_buf (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clr_wr_i   (clr_wr_s),
    .wr_en_i    (wr_en_s),
    .wr_idx_i   (wcnt_q[1:0]),
    .wr_col_i   (col_q),
    .wr_data_i  (rom_data_i),
    .swap_i     (swap_s),
    .discard_i  (abort_s),
    .look_col_i (h_tile_s),
    .hit_o      (look_hit_s),
    .data_o     (look_data_s)
  );

  assign rom_req_o   = rom_req_q;
  assign rom_charc_o = rom_charc_q;
  assign rom_dir_o   = rom_dir_q;
  assign rom_index_o = rom_index_q;
  assign busy_o      = busy_q;
  assign colour_o    = colour_q;

`ifdef SPRITE_OVERFLOW_EN
  // The flag rises as soon as a hit is dropped; the swap hands the finished line's status to the display.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_line_q        <= 1'b0;
      sprite_overflow_q <= 1'b0;
    end else if (swap_s) begin
      ovf_line_q        <= 1'b0;
      sprite_overflow_q <= ovf_line_q;
    end else if (ovf_hit_s) begin
      ovf_line_q        <= 1'b1;
      sprite_overflow_q <= 1'b1;
    end else begin
      ovf_line_q        <= ovf_line_q;
      sprite_overflow_q <= sprite_overflow_q;
    end
  end

  assign sprite_overflow_o = sprite_overflow_q;
`else
  // Hits beyond the buffer capacity are dropped silently.
`endif

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler: directed and randomised lines
// checked against a slot-list reference model of fetches and pixels.
module tb_sprite_line_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  counter_h, counter_v;
  logic [79:0] slot_pos;
  logic [19:0] slot_orien;
  logic [39:0] slot_charc;
  logic        rom_req;
  logic [3:0]  rom_charc;
  logic [1:0]  rom_dir;
  logic [2:0]  rom_index;
  logic [7:0]  rom_data;
  logic        colour;
  logic        busy;
`ifdef SPRITE_OVERFLOW_EN
  logic        sprite_overflow;
`endif

  sprite_line_scheduler dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .counter_h_i  (counter_h),
    .counter_v_i  (counter_v),
    .slot_pos_i   (slot_pos),
    .slot_orien_i (slot_orien),
    .slot_charc_i (slot_charc),
    .rom_req_o    (rom_req),
    .rom_charc_o  (rom_charc),
    .rom_dir_o    (rom_dir),
    .rom_index_o  (rom_index),
    .rom_data_i   (rom_data),
    .colour_o     (colour),
    .busy_o       (busy)
`ifdef SPRITE_OVERFLOW_EN
    ,.sprite_overflow_o (sprite_overflow)
`endif
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int pos_a [10];
  int orien_a [10];
  int charc_a [10];

  // Reference display contents: up to 4 (col, data) pairs in priority order.
  int disp_n;
  int disp_col [4];
  int disp_dat [4];
  int exp_ovf;

  bit         force_en;
  logic [7:0] force_val;
  logic       last_req, prev_req;
  logic [8:0] last_addr, prev_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rom_fn(input int c, input int d, input int i);
    if (force_en) return force_val;
    return 8'((c * 37 + d * 11 + i * 73 + 5) % 256) ^ 8'h5A;
  endfunction

  function automatic int exp_colour(input int hh, input int vv);
    if (hh >= 640 || vv >= 480) return 1;
    for (int k = 0; k < disp_n; k++) begin
      if (disp_col[k] == hh / 40) return (disp_dat[k] >> ((hh % 40) / 5)) & 1;
    end
    return 1;
  endfunction

  task automatic pack();
    for (int i = 0; i < 10; i++) begin
      slot_pos[i*8 +: 8]   = 8'(pos_a[i]);
      slot_orien[i*2 +: 2] = 2'(orien_a[i]);
      slot_charc[i*4 +: 4] = 4'(charc_a[i]);
    end
  endtask

  task automatic hide_all();
    for (int i = 0; i < 10; i++) begin
      pos_a[i] = 200; orien_a[i] = i % 4; charc_a[i] = i;
    end
  endtask

  // One clock: drive inputs, let the edge pass, sample outputs 1 time unit later.
  // ROM data is valid only in the cycle right after the cycle rom_req was high.
  task automatic drive_cycle(input int hh, input int vv, input bit rst);
    counter_h = 10'(hh);
    counter_v = 10'(vv);
    reset     = rst;
    rom_data  = prev_req ? rom_fn(int'(prev_addr[8:5]), int'(prev_addr[4:3]), int'(prev_addr[2:0]))
                         : 8'($urandom);
    @(posedge clk);
    #1;
    prev_req  = last_req;
    prev_addr = last_addr;
    last_req  = rom_req;
    last_addr = {rom_charc, rom_dir, rom_index};
  endtask

  // Horizontal blanking of line vv: the scan for target line vv+1, then the swap.
  task automatic scan_line(input int vv);
    int t, row, idx, nexp, hits, nreq, nbusy, addr_err, col_err;
    int exp_addr [4];
    int new_col [4];
    int new_dat [4];
    t = (vv == 524) ? 0 : vv + 1;
    row = t / 40;
    idx = (t % 40) / 5;
    nexp = 0; hits = 0; nreq = 0; nbusy = 0; addr_err = 0; col_err = 0;
    if (t < 480) begin
      for (int s = 0; s < 10; s++) begin
        if (pos_a[s] < 192 && pos_a[s] / 16 == row) begin
          hits++;
          if (nexp < 4) begin
            exp_addr[nexp] = charc_a[s] * 32 + orien_a[s] * 8 + idx;
            new_col[nexp]  = pos_a[s] % 16;
            new_dat[nexp]  = int'(rom_fn(charc_a[s], orien_a[s], idx));
            nexp++;
          end
        end
      end
    end
    pack();
    for (int hh = 640; hh < 800; hh++) begin
      drive_cycle(hh, vv, 1'b0);
      if (rom_req === 1'b1) begin
        if (nreq < nexp && int'({rom_charc, rom_dir, rom_index}) != exp_addr[nreq]) addr_err++;
        nreq++;
      end
      if (busy === 1'b1) nbusy++;
      if (colour !== 1'b1) col_err++;
    end
    chk($sformatf("v%0d rom_req count", vv), nreq, nexp);
    chk($sformatf("v%0d busy cycles", vv), nbusy, (t < 480) ? 10 + 2 * nexp : 0);
    chk($sformatf("v%0d rom address errors", vv), addr_err, 0);
    chk($sformatf("v%0d blanking colour errors", vv), col_err, 0);
    disp_n = nexp;
    for (int k = 0; k < nexp; k++) begin
      disp_col[k] = new_col[k];
      disp_dat[k] = new_dat[k];
    end
    exp_ovf = (hits > 4) ? 1 : 0;
  endtask

  // Active part of line vv; colour observed after the edge at h must equal the pixel for h.
  task automatic display_line(input int vv);
    int bad, first_h;
    bad = 0; first_h = -1;
    for (int hh = 0; hh < 640; hh++) begin
      drive_cycle(hh, vv, 1'b0);
`ifdef SPRITE_OVERFLOW_EN
      if (hh == 0) chk($sformatf("v%0d sprite_overflow", vv), sprite_overflow, exp_ovf);
`endif
      if (colour !== 1'(exp_colour(hh, vv))) begin
        if (bad == 0) first_h = hh;
        bad++;
      end
    end
    chk($sformatf("v%0d pixel errors (first h=%0d)", vv, first_h), bad, 0);
  endtask

  initial begin
    int v, t, nreq;
    reset = 1'b1;
    counter_h = 10'd0; counter_v = 10'd0; rom_data = 8'd0;
    last_req = 1'b0; prev_req = 1'b0; last_addr = 9'd0; prev_addr = 9'd0;
    force_en = 1'b0; force_val = 8'd0;
    disp_n = 0; exp_ovf = 0;
    hide_all();
    pack();
    repeat (3) drive_cycle(0, 0, 1'b1);
    chk("reset colour", colour, 1);
    chk("reset rom_req", rom_req, 0);
    chk("reset busy", busy, 0);
    chk("reset rom address", {rom_charc, rom_dir, rom_index}, 0);

    // Single slot on tile row 1, first sprite row of the tile.
    hide_all();
    pos_a[0] = 17; charc_a[0] = 7; orien_a[0] = 2;
    force_en = 1'b1; force_val = 8'hA5;
    scan_line(39);
    chk("single rom_charc", rom_charc, 7);
    chk("single rom_index", rom_index, 0);
    chk("single rom_dir", rom_dir, 2);
    display_line(40);
    force_en = 1'b0;

    // Every slot hidden.
    hide_all();
    scan_line(100);
    display_line(101);

    // Six slots on the same tile: only the first four are fetched, slot 0 shown.
    hide_all();
    for (int s = 0; s < 6; s++) pos_a[s] = 3;
    scan_line(10);
    display_line(11);

    // Target line wraps to 0; then the last active line; then a blank target.
    hide_all();
    pos_a[0] = 0;
    scan_line(524);
    chk("wrap rom_index", rom_index, 0);
    display_line(0);
    hide_all();
    pos_a[3] = 176 + 5; pos_a[7] = 176 + 15;
    scan_line(478);
    display_line(479);
    scan_line(479);
    display_line(480);

    // Randomised lines, biased so that many slots land on the target tile row.
    for (int n = 0; n < 8; n++) begin
      v = $urandom_range(0, 524);
      t = (v == 524) ? 0 : v + 1;
      for (int s = 0; s < 10; s++) begin
        case ($urandom_range(0, 3))
          0:       pos_a[s] = 192 + $urandom_range(0, 63);
          1:       pos_a[s] = $urandom_range(0, 255);
          default: pos_a[s] = ((t / 40) % 12) * 16 + $urandom_range(0, 15);
        endcase
        orien_a[s] = $urandom_range(0, 3);
        charc_a[s] = $urandom_range(0, 15);
      end
      scan_line(v);
      display_line((v + 1) % 525);
    end

    // Reset while waiting for ROM data aborts the scan and empties both buffers.
    hide_all();
    pos_a[0] = 5 * 16 + 2;
    pack();
    drive_cycle(640, 200, 1'b0);
    chk("abort scan busy", busy, 1);
    drive_cycle(641, 200, 1'b0);
    chk("abort fetch rom_req", rom_req, 1);
    drive_cycle(642, 200, 1'b0);
    chk("abort wait busy", busy, 1);
    drive_cycle(643, 200, 1'b1);
    chk("abort busy", busy, 0);
    chk("abort colour", colour, 1);
    chk("abort rom_req", rom_req, 0);
    nreq = 0;
    for (int hh = 644; hh < 800; hh++) begin
      drive_cycle(hh, 200, 1'b0);
      if (rom_req === 1'b1) nreq++;
    end
    chk("abort no rom_req after release", nreq, 0);
    disp_n = 0; exp_ovf = 0;
    display_line(201);
    scan_line(201);
    display_line(202);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

Interface
REQ-001 clk  in  1  system pixel clock; all logic SHALL be clocked on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 counter_H  in  10  horizontal pixel counter: 0..799, active region 0..639.
REQ-004 counter_V  in  10  vertical line counter: 0..524, active region 0..479.
REQ-005 slot_pos  in  80  10 slots x 8 bits: tile position, col = pos%16, row = pos/16; values >=192 mean hidden.
REQ-006 slot_orien  in  20  10 slots x 2 bits: orientation passed to the ROM.
REQ-007 slot_charc  in  40  10 slots x 4 bits: asset code passed to the ROM.
REQ-008 rom_req  out  1  ROM read strobe, one cycle wide.
REQ-009 rom_charc / rom_dir / rom_index  out  4/2/3  ROM address: asset, orientation, sprite row 0..7.
REQ-010 rom_data  in  8  ROM row data, valid exactly 1 cycle after rom_req.
REQ-011 colour  out  1  pixel output: 0 = black, 1 = white.
REQ-012 busy  out  1  high while a line scan is in progress.

Function
REQ-013 The scan SHALL start on the cycle where counter_H==640 and the FSM is in IDLE.
- Target line: T = counter_V+1; T wraps to 0 when counter_V==524.
- If T>=480, no slot SHALL be fetched and the write buffer SHALL be cleared.
REQ-014 The FSM SHALL have the states IDLE, SCAN, FETCH, WAIT and DONE.
- IDLE->SCAN on trigger.
- SCAN tests one slot per cycle, in slot order 0..9.
- SCAN->FETCH on a hit; SCAN->DONE after slot 9.
- FETCH asserts rom_req for one cycle, then goes to WAIT.
- WAIT latches rom_data, then returns to SCAN at the next slot.
- DONE->IDLE after 1 cycle.
REQ-015 A slot SHALL be a hit when pos<192 and pos/16 == T/40.
- The ROM address SHALL be rom_index = (T%40)/5 with the slot's charc and orientation.
REQ-016 The write buffer SHALL hold at most 4 entries, each {valid, col[3:0], data[7:0]}.
- Entries fill in slot order, so a lower slot index has higher priority.
- Hits beyond the 4th SHALL be skipped without issuing rom_req.
REQ-017 The write and display buffers SHALL swap on the cycle where counter_H==799.
- If the scan is not in IDLE at the swap, the swap SHALL still occur and the incomplete entries SHALL be discarded.
- This cannot happen in normal timing: worst case is 10 slots x 3 cycles + 2 cycles, under 160 cycles.
REQ-018 colour SHALL be registered with 1-cycle latency.
- Outside the active region, colour SHALL be 1.
- Inside the active region, colour SHALL come from the lowest-index valid display entry with col == counter_H/40, using bit data[(counter_H%40)/5].
- With no matching entry, colour SHALL be 1.
REQ-019 busy SHALL be high in SCAN, FETCH and WAIT, and low otherwise.
REQ-020 Slot inputs SHALL be sampled during the scan only; changes between scans SHALL take effect on the next line.

Reset
REQ-021 On reset the FSM SHALL enter IDLE and both buffers SHALL be invalidated.
- colour = 1, rom_req = 0, busy = 0, rom_charc/rom_dir/rom_index = 0.
REQ-022 Reset asserted mid-scan SHALL abort the scan on that edge.
- After release, no scan SHALL start until the next counter_H==640.

Configuration
REQ-023 Macro SPRITE_OVERFLOW_EN controls the overflow output.
- Defined: the block SHALL add output sprite_overflow (1 bit), set when a 5th hit is seen in a scan.
- sprite_overflow SHALL stay set until the next buffer swap, then show the just-completed line's status during display of that line.
- Undefined: the port and its logic SHALL be absent; skipped hits are silent.

Structure
REQ-024 A shared package frame_pkg SHALL hold:
- TILELEN_PIXEL=40, UPSCALE=5, SCREENSIZE_H=16, SCREENSIZE_V=12, H_ACTIVE=640, V_ACTIVE=480, H_TOTAL=800, V_TOTAL=525, HIDDEN_POS=192;
- the asset codes HEART..GOAT_2 (0..8);
- the scheduler FSM state enum.
REQ-025 One sub-module, sprite_line_buf, SHALL implement the double-buffered 4-entry store: write port, swap, and combinational lookup by column.

Verification
REQ-026 Single slot: slot0 pos=17, charc=7, line V=39 trigger (T=40), rom_data=8'hA5 -> exactly one rom_req with index 0, charc 7; on line 40, pixels H=40..79 follow A5 bits in 5-pixel groups; elsewhere colour=1.
REQ-027 Hidden slots: all pos=200 -> no rom_req in the scan; busy is high for 10 cycles; colour stays 1 on the whole next line.
REQ-028 Priority and capacity: slots 0..5 all pos=3 -> exactly 4 rom_req (slots 0..3), and the line shows slot0's data; with SPRITE_OVERFLOW_EN, sprite_overflow=1.
REQ-029 Wrap-around: counter_V=524, slot pos=0 -> fetch with index 0 for T=0; counter_V=479 -> no fetch, buffer cleared.
REQ-030 Reset mid-scan: assert reset while in WAIT -> next cycle FSM in IDLE, busy=0, colour=1; no rom_req until counter_H next reaches 640.
REQ-031 Latency: a hit pixel at counter_H=h SHALL appear on colour at cycle h+1.
